// File: rtl/multisim_pull_fifo.sv
// First-word-fall-through elastic buffer between the multisim pull client and the DUT consumer.
// Defining MULTISIM_PULL_FIFO_STATS_EN adds the saturating stall_full/stall_empty counters.
module multisim_pull_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_rdy,
    output logic                         out_vld,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_rdy,
`ifdef MULTISIM_PULL_FIFO_STATS_EN
    output logic [31:0]                  stall_full,
    output logic [31:0]                  stall_empty,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  push, pop, full, empty;

    assign full     = (count_q == Full);
    assign empty    = (count_q == '0);
    // in_rdy looks only at occupancy so out_rdy never reaches the client combinationally.
    assign in_rdy   = !rst && !full;
    assign out_vld  = !empty;
    assign out_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign push     = in_vld && in_rdy;
    assign pop      = out_vld && out_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale words are never exposed since out_vld follows count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef MULTISIM_PULL_FIFO_STATS_EN
    logic [31:0] stall_full_q, stall_empty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_full_q  <= '0;
            stall_empty_q <= '0;
        end else begin
            if (in_vld && full && (stall_full_q != 32'hFFFF_FFFF)) begin
                stall_full_q <= stall_full_q + 32'd1;
            end
            if (out_rdy && empty && (stall_empty_q != 32'hFFFF_FFFF)) begin
                stall_empty_q <= stall_empty_q + 32'd1;
            end
        end
    end

    assign stall_full  = stall_full_q;
    assign stall_empty = stall_empty_q;
`endif

endmodule

// File: tb/tb_multisim_pull_fifo.sv
// Scoreboard bench for multisim_pull_fifo: accepted words are queued, a monitor checks pops.
// Stall counters are checked only when MULTISIM_PULL_FIFO_STATS_EN is defined.
module tb_multisim_pull_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [63:0] in_data;
    logic        in_rdy;
    logic        out_vld;
    logic [63:0] out_data;
    logic        out_rdy;
    logic [2:0]  count;
`ifdef MULTISIM_PULL_FIFO_STATS_EN
    logic [31:0] stall_full;
    logic [31:0] stall_empty;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    multisim_pull_fifo #(
        .DATA_WIDTH (64),
        .DEPTH      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_vld      (in_vld),
        .in_data     (in_data),
        .in_rdy      (in_rdy),
        .out_vld     (out_vld),
        .out_data    (out_data),
        .out_rdy     (out_rdy),
`ifdef MULTISIM_PULL_FIFO_STATS_EN
        .stall_full  (stall_full),
        .stall_empty (stall_empty),
`endif
        .count       (count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; a word the DUT will accept is queued as expected output.
    task automatic drive(input logic v, input logic [63:0] d, input logic r);
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        @(negedge clk);
        if (v && in_rdy) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake seen mid-cycle completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_underflow: got 0x%0h expected no word", out_data);
            end else begin
                chk("pop_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_vld = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset held with a client word pending
        for (int i = 0; i < 3; i++) drive(1'b1, 64'hEE, 1'b0);
        chk("rst_in_rdy", {63'd0, in_rdy}, 64'd0);
        chk("rst_out_vld", {63'd0, out_vld}, 64'd0);
        chk("rst_count", {61'd0, count}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_rdy", {63'd0, in_rdy}, 64'd1);

        // 2: fill, word 0x55 held off while full, then drain in order
        drive(1'b1, 64'h11, 1'b0);
        chk("first_word_out_vld", {63'd0, out_vld}, 64'd1);
        chk("first_word_fwft", out_data, 64'h11);
        drive(1'b1, 64'h22, 1'b0);
        drive(1'b1, 64'h33, 1'b0);
        drive(1'b1, 64'h44, 1'b0);
        chk("fill_count", {61'd0, count}, 64'd4);
        chk("fill_in_rdy", {63'd0, in_rdy}, 64'd0);
        drive(1'b1, 64'h55, 1'b0);
        chk("full_hold_count", {61'd0, count}, 64'd4);
        drive(1'b1, 64'h55, 1'b1);
        chk("full_pop_count", {61'd0, count}, 64'd3);
        drive(1'b1, 64'h55, 1'b1);
        chk("push_pop_count", {61'd0, count}, 64'd3);
        for (int i = 0; i < 3; i++) drive(1'b0, 64'h0, 1'b1);
        chk("drain_count", {61'd0, count}, 64'd0);
        chk("drain_sb", 64'(exp_q.size()), 64'd0);

        // 3: streaming 0..99 with no bubbles
        drive(1'b1, 64'd0, 1'b1);
        chk("stream_start_count", {61'd0, count}, 64'd1);
        for (int i = 1; i < 100; i++) begin
            drive(1'b1, 64'(i), 1'b1);
            chk("stream_count", {61'd0, count}, 64'd1);
            chk("stream_out_vld", {63'd0, out_vld}, 64'd1);
        end
        drive(1'b0, 64'h0, 1'b1);
        chk("stream_end_count", {61'd0, count}, 64'd0);
        chk("stream_sb", 64'(exp_q.size()), 64'd0);

        // 4: full with a simultaneous pop request: no push that cycle
        for (int i = 0; i < 4; i++) drive(1'b1, 64'hA0 + 64'(i), 1'b0);
        drive(1'b1, 64'hA4, 1'b1);
        chk("full_popreq_count", {61'd0, count}, 64'd3);
        drive(1'b1, 64'hA4, 1'b0);
        chk("refill_count", {61'd0, count}, 64'd4);
        for (int i = 0; i < 4; i++) drive(1'b0, 64'h0, 1'b1);
        chk("t4_sb", 64'(exp_q.size()), 64'd0);

        // 5: reset with three words stored
        for (int i = 0; i < 3; i++) drive(1'b1, 64'hC0 + 64'(i), 1'b0);
        chk("pre_rst_count", {61'd0, count}, 64'd3);
        rst = 1'b1;
        drive(1'b0, 64'h0, 1'b0);
        exp_q.delete();
        rst = 1'b0;
        chk("mid_rst_count", {61'd0, count}, 64'd0);
        chk("mid_rst_out_vld", {63'd0, out_vld}, 64'd0);
        drive(1'b1, 64'hAB, 1'b0);
        chk("post_rst_head", out_data, 64'hAB);
        drive(1'b0, 64'h0, 1'b1);
        chk("post_rst_count", {61'd0, count}, 64'd0);
        chk("post_rst_sb", 64'(exp_q.size()), 64'd0);

`ifdef MULTISIM_PULL_FIFO_STATS_EN
        // 6: stall counters
        rst = 1'b1;
        drive(1'b0, 64'h0, 1'b0);
        rst = 1'b0;
        chk("stats_rst_full", {32'd0, stall_full}, 64'd0);
        chk("stats_rst_empty", {32'd0, stall_empty}, 64'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 64'hD0 + 64'(i), 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 64'hFF, 1'b0);
        chk("stall_full", {32'd0, stall_full}, 64'd5);
        for (int i = 0; i < 4; i++) drive(1'b0, 64'h0, 1'b1);
        for (int i = 0; i < 7; i++) drive(1'b0, 64'h0, 1'b1);
        chk("stall_empty", {32'd0, stall_empty}, 64'd7);
        chk("stall_full_hold", {32'd0, stall_full}, 64'd5);
        chk("stats_sb", 64'(exp_q.size()), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
